// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types plus the writeback scheduler's starvation constants.
package cpu_types_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;
    localparam int NREGS  = 1 << REG_W;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [NREGS-1:0]  regmask_t;

    localparam int STARVE_W             = 4;
    localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy/ownership tracking: issue hazard check, set on issue,
// clear on writeback, selective clear on flush, and sticky protocol error.
module regfile_scoreboard
    import cpu_types_pkg::*;
(
    input  logic     clk,
    input  logic     nRST,
    input  logic     iss_valid,
    input  regbits_t iss_rs,
    input  regbits_t iss_rt,
    input  regbits_t iss_rd,
    input  logic     iss_rs_used,
    input  logic     iss_rt_used,
    input  logic     iss_rd_used,
    input  logic     iss_mdu,
    input  logic     hold_pipe,
    input  logic     flush,
    input  logic     wen,
    input  regbits_t wsel,
    output logic     iss_stall,
    output logic     err
);

    regmask_t busy_q, busy_d;
    regmask_t own_mdu_q, own_mdu_d;
    logic     err_q, err_d;
    logic     hazard;
    logic     accept;

    assign hazard = (iss_rs_used & busy_q[iss_rs])
                  | (iss_rt_used & busy_q[iss_rt])
                  | (iss_rd_used & busy_q[iss_rd]);

    assign iss_stall = (iss_valid & hazard) | hold_pipe;
    assign accept    = iss_valid & ~iss_stall & ~flush;
    assign err       = err_q;

    always_comb begin
        // NOTE: every output gets its hold value first, so no path through this block can infer a latch.
        busy_d    = busy_q;
        own_mdu_d = own_mdu_q;
        err_d     = err_q;

        if (flush) begin
            busy_d = busy_q & own_mdu_q;
        end

        // Clear before set: a forced same-register clear+set leaves the register busy.
        if (wen && (wsel != '0)) begin
            if (!busy_q[wsel]) begin
                err_d = 1'b1;
            end
            busy_d[wsel]    = 1'b0;
            own_mdu_d[wsel] = 1'b0;
        end

        if (accept && iss_rd_used && (iss_rd != '0)) begin
            busy_d[iss_rd]    = 1'b1;
            own_mdu_d[iss_rd] = iss_mdu;
        end

        busy_d[0]    = 1'b0;
        own_mdu_d[0] = 1'b0;
    end

    // NOTE: the busy/own_mdu arrays are ordinary flops, not RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy_q    <= '0;
            own_mdu_q <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            busy_q    <= busy_d;
            own_mdu_q <= own_mdu_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: fixed-priority pwb/MDU write-port mux, MDU starvation
// guard driving hold_pipe, and the register busy scoreboard.
module regfile_wb_scheduler
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic     clk,
    input  logic     nRST,
    input  logic     iss_valid,
    input  regbits_t iss_rs,
    input  regbits_t iss_rt,
    input  regbits_t iss_rd,
    input  logic     iss_rs_used,
    input  logic     iss_rt_used,
    input  logic     iss_rd_used,
    input  logic     iss_mdu,
    output logic     iss_stall,
    input  logic     pwb_valid,
    input  regbits_t pwb_sel,
    input  word_t    pwb_dat,
    input  logic     mdu_valid,
    input  regbits_t mdu_sel,
    input  word_t    mdu_dat,
    output logic     mdu_ready,
    input  logic     flush,
    output logic     hold_pipe,
    output logic     wen,
    output regbits_t wsel,
    output word_t    wdat,
    output logic     err
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                hold_pipe_q, hold_pipe_d;

    assign mdu_ready = mdu_valid & ~pwb_valid;
    assign hold_pipe = hold_pipe_q;

    always_comb begin
        wen  = 1'b0;
        wsel = '0;
        wdat = '0;
        if (pwb_valid) begin
            wen  = 1'b1;
            wsel = pwb_sel;
            wdat = pwb_dat;
        end else if (mdu_valid) begin
            wen  = 1'b1;
            wsel = mdu_sel;
            wdat = mdu_dat;
        end
    end

    // Counter only runs while the MDU is actually being denied; a grant or a
    // withdrawn request resets the starvation window.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (mdu_ready || !mdu_valid) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
        hold_pipe_d = (starve_cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            starve_cnt_q <= '0;
            hold_pipe_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            hold_pipe_q  <= hold_pipe_d;
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk         (clk),
        .nRST        (nRST),
        .iss_valid   (iss_valid),
        .iss_rs      (iss_rs),
        .iss_rt      (iss_rt),
        .iss_rd      (iss_rd),
        .iss_rs_used (iss_rs_used),
        .iss_rt_used (iss_rt_used),
        .iss_rd_used (iss_rd_used),
        .iss_mdu     (iss_mdu),
        .hold_pipe   (hold_pipe_q),
        .flush       (flush),
        .wen         (wen),
        .wsel        (wsel),
        .iss_stall   (iss_stall),
        .err         (err)
    );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: expected register-file writes are queued
// when writeback stimulus is driven and compared when the write port is sampled.
module tb_regfile_wb_scheduler;
    import cpu_types_pkg::*;

    logic     clk;
    logic     nRST;
    logic     iss_valid;
    regbits_t iss_rs, iss_rt, iss_rd;
    logic     iss_rs_used, iss_rt_used, iss_rd_used, iss_mdu;
    logic     iss_stall;
    logic     pwb_valid;
    regbits_t pwb_sel;
    word_t    pwb_dat;
    logic     mdu_valid;
    regbits_t mdu_sel;
    word_t    mdu_dat;
    logic     mdu_ready;
    logic     flush;
    logic     hold_pipe;
    logic     wen;
    regbits_t wsel;
    word_t    wdat;
    logic     err;

    typedef struct packed {
        regbits_t sel;
        word_t    dat;
    } wb_exp_t;

    wb_exp_t wb_q[$];
    int      errors = 0;
    int      checks = 0;

    regfile_wb_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .nRST        (nRST),
        .iss_valid   (iss_valid),
        .iss_rs      (iss_rs),
        .iss_rt      (iss_rt),
        .iss_rd      (iss_rd),
        .iss_rs_used (iss_rs_used),
        .iss_rt_used (iss_rt_used),
        .iss_rd_used (iss_rd_used),
        .iss_mdu     (iss_mdu),
        .iss_stall   (iss_stall),
        .pwb_valid   (pwb_valid),
        .pwb_sel     (pwb_sel),
        .pwb_dat     (pwb_dat),
        .mdu_valid   (mdu_valid),
        .mdu_sel     (mdu_sel),
        .mdu_dat     (mdu_dat),
        .mdu_ready   (mdu_ready),
        .flush       (flush),
        .hold_pipe   (hold_pipe),
        .wen         (wen),
        .wsel        (wsel),
        .wdat        (wdat),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_iss(input logic v, input regbits_t rs, input logic rsu,
                           input regbits_t rt, input logic rtu,
                           input regbits_t rd, input logic rdu, input logic m);
        iss_valid   = v;
        iss_rs      = rs;
        iss_rs_used = rsu;
        iss_rt      = rt;
        iss_rt_used = rtu;
        iss_rd      = rd;
        iss_rd_used = rdu;
        iss_mdu     = m;
    endtask

    // Drives both writeback sources for one cycle and queues the write the
    // port must carry: pipeline WB wins, otherwise a pending MDU result.
    task automatic drive_wb(input logic pv, input regbits_t ps, input word_t pd,
                            input logic mv, input regbits_t ms, input word_t md);
        pwb_valid = pv;
        pwb_sel   = ps;
        pwb_dat   = pd;
        mdu_valid = mv;
        mdu_sel   = ms;
        mdu_dat   = md;
        if (pv)      wb_q.push_back('{sel: ps, dat: pd});
        else if (mv) wb_q.push_back('{sel: ms, dat: md});
    endtask

    // Called at the negative edge: retire this cycle's expected write, then
    // move to just after the next rising edge.
    task automatic finish_cycle();
        wb_exp_t exp_wb;
        checks++;
        if (wb_q.size() != 0) begin
            exp_wb = wb_q.pop_front();
            if (wen !== 1'b1 || wsel !== exp_wb.sel || wdat !== exp_wb.dat) begin
                errors++;
                $display("FAIL wb_port: got wen=%b wsel=%0d wdat=%h, want wen=1 wsel=%0d wdat=%h",
                         wen, wsel, wdat, exp_wb.sel, exp_wb.dat);
            end
        end else if (wen !== 1'b0) begin
            errors++;
            $display("FAIL wb_idle: got wen=%b wsel=%0d, want wen=0", wen, wsel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRST  = 1'b0;
        flush = 1'b0;
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        #2;
        checks++;
        if ({iss_stall, mdu_ready, hold_pipe, wen, err} !== 5'b0 || wsel !== '0 || wdat !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b rdy=%b hold=%b wen=%b err=%b wsel=%0d wdat=%h, want all 0",
                     iss_stall, mdu_ready, hold_pipe, wen, err, wsel, wdat);
        end
        @(posedge clk);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_raw_stall();
        set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++; $display("FAIL raw_issue_rd5: got stall=%b want 0", iss_stall);
        end
        finish_cycle();

        set_iss(1'b1, 5'd5, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        drive_wb(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++; $display("FAIL raw_stall_rs5: got stall=%b want 1", iss_stall);
        end
        finish_cycle();

        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++; $display("FAIL raw_release_rs5: got stall=%b want 0", iss_stall);
        end
        finish_cycle();
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_arbitration();
        set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        finish_cycle();
        set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1, 1'b1);
        @(negedge clk);
        finish_cycle();
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        drive_wb(1'b1, 5'd3, 32'h3333_0003, 1'b1, 5'd7, 32'h7777_0007);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b0 || wsel !== 5'd3) begin
            errors++; $display("FAIL arb_pwb_wins: got rdy=%b wsel=%0d want rdy=0 wsel=3", mdu_ready, wsel);
        end
        finish_cycle();

        drive_wb(1'b0, '0, '0, 1'b1, 5'd7, 32'h7777_0007);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h7777_0007) begin
            errors++; $display("FAIL arb_mdu_grant: got rdy=%b wsel=%0d wdat=%h want rdy=1 wsel=7 wdat=77770007",
                               mdu_ready, wsel, wdat);
        end
        finish_cycle();

        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL arb_no_err: got err=%b want 0", err);
        end
        finish_cycle();
    endtask

    task automatic test_starvation();
        set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd10, 1'b1, 1'b1);
        @(negedge clk);
        finish_cycle();
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        for (int c = 1; c <= 5; c++) begin
            drive_wb(1'b1, 5'd0, word_t'(c), 1'b1, 5'd10, 32'h0000_00A0);
            @(negedge clk);
            checks++;
            if (hold_pipe !== (c == 5) || mdu_ready !== 1'b0) begin
                errors++; $display("FAIL starve_cycle%0d: got hold=%b rdy=%b want hold=%b rdy=0",
                                   c, hold_pipe, mdu_ready, (c == 5));
            end
            finish_cycle();
        end

        drive_wb(1'b0, '0, '0, 1'b1, 5'd10, 32'h0000_00A0);
        @(negedge clk);
        checks++;
        if (mdu_ready !== 1'b1 || hold_pipe !== 1'b1 || iss_stall !== 1'b1) begin
            errors++; $display("FAIL starve_bubble: got rdy=%b hold=%b stall=%b want 1 1 1",
                               mdu_ready, hold_pipe, iss_stall);
        end
        finish_cycle();

        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (hold_pipe !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL starve_release: got hold=%b err=%b want 0 0", hold_pipe, err);
        end
        finish_cycle();
    endtask

    task automatic test_flush();
        set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd4, 1'b1, 1'b0);
        @(negedge clk);
        finish_cycle();
        set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd9, 1'b1, 1'b1);
        @(negedge clk);
        finish_cycle();
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        finish_cycle();
        flush = 1'b0;

        set_iss(1'b1, 5'd4, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++; $display("FAIL flush_clears_r4: got stall=%b want 0", iss_stall);
        end
        finish_cycle();

        set_iss(1'b1, '0, 1'b0, 5'd9, 1'b1, '0, 1'b0, 1'b0);
        drive_wb(1'b0, '0, '0, 1'b1, 5'd9, 32'h9999_0009);
        @(negedge clk);
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++; $display("FAIL flush_keeps_r9: got stall=%b want 1", iss_stall);
        end
        finish_cycle();

        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (iss_stall !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL flush_mdu_clear_r9: got stall=%b err=%b want 0 0", iss_stall, err);
        end
        finish_cycle();
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_r0();
        set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        finish_cycle();
        set_iss(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        drive_wb(1'b1, 5'd0, 32'h0BAD_F00D, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++; $display("FAIL r0_no_stall: got stall=%b want 0", iss_stall);
        end
        finish_cycle();
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL r0_no_err: got err=%b want 0", err);
        end
        finish_cycle();
    endtask

    task automatic test_err_and_reset();
        drive_wb(1'b1, 5'd12, 32'h1212_1212, 1'b0, '0, '0);
        @(negedge clk);
        finish_cycle();
        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b1) begin
                errors++; $display("FAIL err_sticky%0d: got err=%b want 1", c, err);
            end
            finish_cycle();
        end

        set_iss(1'b1, '0, 1'b0, '0, 1'b0, 5'd20, 1'b1, 1'b1);
        @(negedge clk);
        finish_cycle();
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            drive_wb(1'b1, 5'd0, 32'h0, 1'b1, 5'd20, 32'h0000_BEEF);
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (hold_pipe !== 1'b1) begin
                    errors++; $display("FAIL pre_reset_hold: got hold=%b want 1", hold_pipe);
                end
            end
            finish_cycle();
        end

        nRST = 1'b0;
        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        set_iss(1'b1, 5'd20, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        checks++;
        if ({hold_pipe, err, iss_stall, wen, mdu_ready} !== 5'b0) begin
            errors++; $display("FAIL async_reset: got hold=%b err=%b stall=%b wen=%b rdy=%b want all 0",
                               hold_pipe, err, iss_stall, wen, mdu_ready);
        end
        @(posedge clk);
        #1;
        nRST = 1'b1;
        set_iss(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        drive_wb(1'b0, '0, '0, 1'b1, 5'd20, 32'h0000_BEEF);
        @(negedge clk);
        finish_cycle();
        drive_wb(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL late_mdu_err: got err=%b want 1", err);
        end
        finish_cycle();
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_arbitration();
        test_starvation();
        test_flush();
        test_r0();
        test_err_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Controller sitting between the decode/issue stage, the two writeback producers (pipeline WB stage and the multi-cycle multiply/divide unit, MDU), and the single write port of the 32×32 register file. It keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards. It arbitrates the two writeback sources onto one write port and prevents MDU starvation by holding the pipeline. The register file itself is unchanged and sees only wen/wsel/wdat.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied MDU cycles before hold_pipe asserts (range 1–15).

Ports:
- clk  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iss_valid  in  1  decode presents an instruction
- iss_rs, iss_rt, iss_rd  in  regbits_t (5)  source/destination register numbers
- iss_rs_used, iss_rt_used, iss_rd_used  in  1  field is a real operand
- iss_mdu  in  1  destination will be written by the MDU
- iss_stall  out  1  instruction must not issue this cycle
- pwb_valid  in  1  pipeline WB write request (cannot be back-pressured)
- pwb_sel  in  regbits_t; pwb_dat  in  word_t (32)
- mdu_valid  in  1  MDU write request; mdu_sel regbits_t; mdu_dat word_t
- mdu_ready  out  1  MDU request granted this cycle
- flush  in  1  squash all in-flight pipeline instructions
- hold_pipe  out  1  freeze pipeline upstream of WB to create a bubble
- wen  out  1; wsel  out  regbits_t; wdat  out  word_t: register file write port
- err  out  1  sticky protocol error

## Operation
- State: busy[31:0], own_mdu[31:0], starve counter (4 bits), hold_pipe flop, err flop. busy[0] and own_mdu[0] are constant 0.
- iss_stall = iss_valid & ((rs_used & busy[rs]) | (rt_used & busy[rt]) | (rd_used & busy[rd])) | hold_pipe.
- Issue accepted = iss_valid & ~iss_stall & ~flush. On accept with rd_used and rd≠0: busy[rd]←1, own_mdu[rd]←iss_mdu.
- Arbitration: pwb has fixed priority. mdu_ready = mdu_valid & ~pwb_valid. Write mux is combinational: wen = pwb_valid | mdu_ready; wsel/wdat from the winner, else 0.
- Completion: when wen and wsel≠0, busy[wsel]←0 and own_mdu[wsel]←0 at the same clock edge. A write to a non-busy register sets err (sticky until reset). Writes to r0 are forwarded but never alter state.
- Starvation: counter increments each cycle with mdu_valid & pwb_valid and saturates at STARVE_LIMIT. hold_pipe registers 1 when the counter reaches STARVE_LIMIT. hold_pipe and counter clear on the cycle after mdu_ready=1 or when mdu_valid drops.
- Flush: clears busy[i] for every i with own_mdu[i]=0. MDU-owned bits survive. A writeback in the same cycle still clears its bit.

## Timing
- Reset: busy=0, own_mdu=0, counter=0, hold_pipe=0, err=0. wen=0 while no request is pending.
- Scoreboard updates are visible the cycle after the edge. There is no same-cycle bypass: an instruction reading a register written this cycle stalls one extra cycle, because the register file read is combinational and the write lands at the edge.
- Set and clear of the same register in the same cycle cannot occur: the WAW stall forbids it. If forced, the clear applies first, then the set, so the final value is busy=1.
- hold_pipe latency: asserted at most STARVE_LIMIT+1 cycles after MDU contention starts. The MDU is granted on the first pwb bubble.
- Reset mid-operation clears everything immediately. In-flight MDU results arriving afterwards set err.

## Structure
- Use cpu_types_pkg regbits_t and word_t. Add STARVE_W (4) and the default STARVE_LIMIT to cpu_types_pkg.
- One sub-module, regfile_scoreboard, holding busy/own_mdu, issue check, set/clear/flush and err. The top level keeps the arbiter mux and the starvation counter.

## Test plan
- Issue r5 (rd_used), then issue with rs=5 → iss_stall=1. After pwb write r5=0xDEADBEEF → wen=1, wsel=5; next cycle stall=0.
- pwb_valid (r3) and mdu_valid (r7) in the same cycle → wsel=3, mdu_ready=0. Next cycle with pwb idle → wsel=7, wdat=mdu_dat, mdu_ready=1.
- Continuous pwb_valid with mdu_valid for 4 cycles (STARVE_LIMIT=4) → hold_pipe=1 on cycle 5. After the pwb bubble → MDU granted and hold_pipe=0 next cycle.
- Busy r4 (pipeline) and r9 (iss_mdu) then flush → busy[4]=0, busy[9]=1. MDU write r9 clears it.
- Issue with rd=0, then pwb write r0 → no stall on r0 ever, wen=1, err=0.
- pwb write to non-busy r12 → err=1 and remains 1 until nRST; nRST mid-activity → all outputs at reset values.
